uart_tx: RTL and testbench

UART transmitter, the transmit-side counterpart of the UART receiver in the same serial link. Accepts a parallel word on a start strobe and serializes it LSB-first as a start bit, `NB_DATA` data bits, an optional parity bit and a stop period. It is paced by the shared 16x-oversampling baud tick from the baud-rate generator, so one bit period always lasts 16 ticks. Sits between the host/interface logic (word source) and the `tx` pad.

---
 rtl/uart_tx.sv | 175 +++++++++++++++++
 tb/tb_uart_tx.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// UART transmitter: start, NB_DATA bits LSB-first, optional even parity, stop.
// Optional parity bit is compiled in with `define UART_TX_PARITY_EN.
module uart_tx #(
    parameter int NB_DATA = 8,
    parameter int SB_TICK = 16
) (
    input  logic               clk,
    input  logic               i_rst_n,
    input  logic               i_tick,
    input  logic               i_tx_start,
    input  logic [NB_DATA-1:0] i_data,
    output logic               o_tx,
    output logic               o_tx_done,
    output logic               o_busy
);

    localparam int SW = $clog2(SB_TICK);
    localparam int NW = $clog2(NB_DATA);

    localparam logic [SW-1:0] S_BIT_LAST  = SW'(15);
    localparam logic [SW-1:0] S_STOP_LAST = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST      = NW'(NB_DATA - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t             r_state;
    state_t             w_state_n;
    logic [SW-1:0]      r_s;
    logic [SW-1:0]      w_s_n;
    logic [NW-1:0]      r_n;
    logic [NW-1:0]      w_n_n;
    logic [NB_DATA-1:0] r_b;
    logic [NB_DATA-1:0] w_b_n;
    logic               r_tx;
    logic               w_tx_n;
    logic               r_done;
    logic               w_done_n;
    logic               r_busy;
    logic               w_busy_n;

`ifdef UART_TX_PARITY_EN
    // b is shifted out by the time parity is sent, so keep it separately
    logic r_par;

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_par <= 1'b0;
        end else if (r_state == S_IDLE && i_tx_start) begin
            r_par <= ^i_data;
        end
    end
`endif

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_s     <= '0;
            r_n     <= '0;
            r_b     <= '0;
            r_tx    <= 1'b1;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_s     <= w_s_n;
            r_n     <= w_n_n;
            r_b     <= w_b_n;
            r_tx    <= w_tx_n;
            r_done  <= w_done_n;
            r_busy  <= w_busy_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_s_n     = r_s;
        w_n_n     = r_n;
        w_b_n     = r_b;
        w_done_n  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (i_tx_start) begin
                    w_b_n     = i_data;
                    w_s_n     = '0;
                    w_state_n = S_START;
                end
            end
            S_START: begin
                if (i_tick) begin
                    if (r_s == S_BIT_LAST) begin
                        w_s_n     = '0;
                        w_n_n     = '0;
                        w_state_n = S_DATA;
                    end else begin
                        w_s_n = r_s + 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (i_tick) begin
                    if (r_s == S_BIT_LAST) begin
                        w_b_n = r_b >> 1;
                        w_s_n = '0;
                        if (r_n == N_LAST) begin
`ifdef UART_TX_PARITY_EN
                            w_state_n = S_PARITY;
`else
                            w_state_n = S_STOP;
`endif
                        end else begin
                            w_n_n = r_n + 1'b1;
                        end
                    end else begin
                        w_s_n = r_s + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (i_tick) begin
                    if (r_s == S_BIT_LAST) begin
                        w_s_n     = '0;
                        w_state_n = S_STOP;
                    end else begin
                        w_s_n = r_s + 1'b1;
                    end
                end
            end
`endif
            S_STOP: begin
                if (i_tick) begin
                    if (r_s == S_STOP_LAST) begin
                        w_s_n     = '0;
                        w_state_n = S_IDLE;
                        w_done_n  = 1'b1;
                    end else begin
                        w_s_n = r_s + 1'b1;
                    end
                end
            end
            default: begin
                w_state_n = S_IDLE;
            end
        endcase
    end

    // Line level is decoded from the next state so o_tx is a plain register
    always_comb begin
        w_tx_n   = 1'b1;
        w_busy_n = (w_state_n != S_IDLE);
        unique case (w_state_n)
            S_IDLE:   w_tx_n = 1'b1;
            S_START:  w_tx_n = 1'b0;
            S_DATA:   w_tx_n = w_b_n[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: w_tx_n = r_par;
`endif
            S_STOP:   w_tx_n = 1'b1;
            default:  w_tx_n = 1'b1;
        endcase
    end

    assign o_tx      = r_tx;
    assign o_tx_done = r_done;
    assign o_busy    = r_busy;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: 8-bit frames at tick = clk/4,
// default stop length plus a second instance with a 2-stop-bit period.
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int NBITS = 10 + P;
    localparam int FR    = 64 * NBITS;
    localparam int FR32  = FR + 64;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick;
    logic       start;
    logic [7:0] data;
    logic       tx, done, busy;
    logic       tx32, done32, busy32;
    logic       tick_en;
    int unsigned cyc = 0;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;
    always @(negedge clk) cyc <= cyc + 1;
    assign tick = tick_en && (cyc[1:0] == 2'd0);

    uart_tx #(.NB_DATA(8), .SB_TICK(16)) dut (
        .clk(clk), .i_rst_n(rst_n), .i_tick(tick),
        .i_tx_start(start), .i_data(data),
        .o_tx(tx), .o_tx_done(done), .o_busy(busy)
    );

    uart_tx #(.NB_DATA(8), .SB_TICK(32)) dut32 (
        .clk(clk), .i_rst_n(rst_n), .i_tick(tick),
        .i_tx_start(start), .i_data(data),
        .o_tx(tx32), .o_tx_done(done32), .o_busy(busy32)
    );

    typedef struct {
        logic [7:0] d;
        logic [7:0] seq;
        logic       par;
    } vec_t;

    vec_t tv[6];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic align();
        @(negedge clk);
        #1;
        while (cyc[1:0] != 2'd0) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((busy || busy32) && k < 3000) begin
            step();
            k++;
        end
        chk("idle_wait", {31'd0, busy || busy32}, 32'd0);
    endtask

    function automatic logic expbit(input int k, input logic [7:0] seq,
                                    input logic par);
        if (k == 0) return 1'b0;
        if (k <= 8) return seq[8-k];
        if (P == 1 && k == 9) return par;
        return 1'b1;
    endfunction

    task automatic send(input vec_t v);
        int d1, d32, np, k;
        wait_idle();
        align();
        data  = v.d;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_tx", {31'd0, tx}, 32'd0);
        chk("start_busy", {31'd0, busy}, 32'd1);
        d1 = -1;
        d32 = -1;
        np = 0;
        for (int c = 1; c <= FR32 + 8; c++) begin
            step();
            if (c % 64 == 32) begin
                k = c / 64;
                if (k < NBITS)
                    chk($sformatf("bit%0d_%0h", k, v.d), {31'd0, tx},
                        {31'd0, expbit(k, v.seq, v.par)});
                if (k <= NBITS)
                    chk($sformatf("bit32_%0d_%0h", k, v.d), {31'd0, tx32},
                        {31'd0, expbit(k, v.seq, v.par)});
            end
            if (done) begin
                np++;
                if (d1 < 0) d1 = c;
                chk("busy_at_done", {31'd0, busy}, 32'd0);
            end
            if (done32 && d32 < 0) d32 = c;
        end
        chk("done_time", d1, FR);
        chk("done_pulses", np, 1);
        chk("done32_time", d32, FR32);
    endtask

    initial begin
        int np;
        int k;
        tv[0] = '{8'hA5, 8'b10100101, 1'b0};
        tv[1] = '{8'h07, 8'b11100000, 1'b1};
        tv[2] = '{8'h3C, 8'b00111100, 1'b0};
        tv[3] = '{8'h01, 8'b10000000, 1'b1};
        tv[4] = '{8'h80, 8'b00000001, 1'b1};
        tv[5] = '{8'hFF, 8'b11111111, 1'b0};

        rst_n   = 1'b0;
        start   = 1'b0;
        data    = 8'h00;
        tick_en = 1'b1;
        repeat (3) step();
        rst_n = 1'b1;
        for (int c = 0; c < 100; c++) begin
            step();
            chk("rst_idle", {29'd0, tx, busy, done}, 32'b100);
            chk("rst_idle32", {29'd0, tx32, busy32, done32}, 32'b100);
        end

        for (int i = 0; i < 6; i++) send(tv[i]);

        // held request: 0x3C then 0xC3 back-to-back
        wait_idle();
        align();
        data  = 8'h3C;
        start = 1'b1;
        step();
        np = 0;
        for (int c = 1; c <= 1500; c++) begin
            step();
            if (c == 100) data = 8'hC3;
            if (c == FR + 20) start = 1'b0;
            if (c == FR - 1)
                chk("b2b_stop_full", {31'd0, tx}, 32'd1);
            if (c == FR)
                chk("b2b_done", {31'd0, done}, 32'd1);
            if (c == FR + 1)
                chk("b2b_restart", {30'd0, tx, busy}, 32'b01);
            if (c > FR + 1 && (c - FR - 1) % 64 == 32) begin
                k = (c - FR - 1) / 64;
                if (k < NBITS)
                    chk($sformatf("b2b_bit%0d", k), {31'd0, tx},
                        {31'd0, expbit(k, 8'b11000011, 1'b0)});
            end
            if (done) np++;
        end
        chk("b2b_frames", np, 2);
        chk("b2b_final_busy", {31'd0, busy}, 32'd0);

        // reset during data bit 3
        wait_idle();
        align();
        data  = 8'h00;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 288; c++) step();
        chk("pre_rst_tx", {31'd0, tx}, 32'd0);
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst", {29'd0, tx, busy, done}, 32'b100);
        chk("async_rst32", {29'd0, tx32, busy32, done32}, 32'b100);
        repeat (5) step();
        rst_n = 1'b1;
        np = 0;
        for (int c = 0; c < 200; c++) begin
            step();
            if (done || busy) np++;
        end
        chk("no_done_after_rst", np, 0);
        send(tv[0]);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
